// File: rtl/stack_ctrl.sv
// stack_ctrl: CPU single-word stack port plus register-file burst save/restore engine.
// Optional: define STACK_CTRL_UFLOW_IRQ_EN to pulse irq on every underflow-type error.
`default_nettype none
`timescale 1ns/1ps

module stack_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_push,
  input  logic        cpu_pop,
  input  logic [31:0] cpu_d,
  output logic        cpu_busy,
  input  logic        burst_start,
  input  logic        burst_save,
  input  logic [3:0]  burst_base,
  input  logic [3:0]  burst_cnt,
  output logic        burst_done,
  output logic        burst_err,
  output logic [3:0]  rf_addr,
  input  logic [31:0] rf_rdata,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  output logic        st_push,
  output logic        st_pop,
  output logic [31:0] st_d,
  input  logic [31:0] st_q,
  output logic [7:0]  depth,
  output logic        ovf,
  output logic        unf,
  input  logic        err_clr,
  output logic        irq
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SAVE  = 3'd1,
    RPOP  = 3'd2,
    RLAST = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  base_q, base_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic [7:0]  depth_q, depth_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        ovf_set, unf_set;
  logic [8:0]  save_need;
  logic [3:0]  pop_idx;

  assign save_need = {1'b0, depth_q} + {5'd0, burst_cnt};
  // Restore walks the register window top-down; 4-bit math wraps 15->0.
  assign pop_idx   = base_q + cnt_q - 4'd1 - idx_q;

  assign cpu_busy  = (state_q != IDLE) | burst_start;
  assign burst_err = err_q & (state_q == DONE);
  assign depth     = depth_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    err_d      = err_q;
    st_push    = 1'b0;
    st_pop     = 1'b0;
    st_d       = 32'd0;
    rf_addr    = 4'd0;
    rf_we      = 1'b0;
    rf_wdata   = 32'd0;
    burst_done = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;

    case (state_q)
      IDLE: begin
        if (burst_start) begin
          base_d = burst_base;
          cnt_d  = burst_cnt;
          idx_d  = 4'd0;
          err_d  = 1'b0;
          if (burst_cnt == 4'd0) begin
            state_d = DONE;
          end else if (burst_save && (save_need > 9'd128)) begin
            err_d   = 1'b1;
            ovf_set = 1'b1;
            state_d = DONE;
          end else if (!burst_save && ({4'd0, burst_cnt} > depth_q)) begin
            err_d   = 1'b1;
            unf_set = 1'b1;
            state_d = DONE;
          end else begin
            state_d = burst_save ? SAVE : RPOP;
          end
        end else if (cpu_push) begin
          if (depth_q == 8'd128) begin
            ovf_set = 1'b1;
          end else begin
            st_push = 1'b1;
            st_d    = cpu_d;
          end
        end else if (cpu_pop) begin
          if (depth_q == 8'd0) begin
            unf_set = 1'b1;
          end else begin
            st_pop = 1'b1;
          end
        end
      end
      SAVE: begin
        st_push = 1'b1;
        rf_addr = base_q + idx_q;
        st_d    = rf_rdata;
        idx_d   = idx_q + 4'd1;
        if (idx_q == cnt_q - 4'd1) state_d = DONE;
      end
      RPOP: begin
        st_pop = 1'b1;
        // The word popped last cycle sits one index above the current pop.
        if (idx_q != 4'd0) begin
          rf_we    = 1'b1;
          rf_addr  = pop_idx + 4'd1;
          rf_wdata = st_q;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == cnt_q - 4'd1) state_d = RLAST;
      end
      RLAST: begin
        rf_we    = 1'b1;
        rf_addr  = base_q;
        rf_wdata = st_q;
        state_d  = DONE;
      end
      DONE: begin
        burst_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign depth_d = depth_q + {7'd0, st_push} - {7'd0, st_pop};
  assign ovf_d   = ovf_set | (ovf_q & ~err_clr);
  assign unf_d   = unf_set | (unf_q & ~err_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= 4'd0;
      cnt_q   <= 4'd0;
      idx_q   <= 4'd0;
      err_q   <= 1'b0;
      depth_q <= 8'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

`ifdef STACK_CTRL_UFLOW_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= unf_set;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports cpu_push/cpu_pop  input  1 each  and cpu_d  input  32: single-word CPU stack requests.
REQ-004 SHALL have port cpu_busy  output  1: CPU requests ignored while high; pipeline stalls on it.
REQ-005 SHALL have ports burst_start  input  1, burst_save  input  1 (1=save, 0=restore), burst_base  input  4, burst_cnt  input  4.
REQ-006 SHALL have ports burst_done  output  1 (one-cycle pulse) and burst_err  output  1 (valid with burst_done).
REQ-007 SHALL have ports rf_addr  output  4, rf_rdata  input  32 (combinational read), rf_wdata  output  32, rf_we  output  1.
REQ-008 SHALL have ports st_push, st_pop  output  1 each, st_d  output  32, st_q  input  32 (registered, valid cycle after st_pop).
REQ-009 SHALL have ports depth  output  8 (0..128), ovf/unf  output  1 each (sticky), err_clr  input  1, irq  output  1.

Function
REQ-010 SHALL implement states IDLE, SAVE, RPOP, RLAST, DONE; cpu_busy = (state != IDLE) | burst_start.
REQ-011 In IDLE, burst_start SHALL take priority; CPU request in that cycle dropped.
REQ-012 In IDLE without burst_start, cpu_push SHALL drive st_push=1, st_d=cpu_d, depth+1 same edge.
REQ-013 In IDLE, cpu_pop SHALL drive st_pop=1, depth-1; cpu_push and cpu_pop together: push served, pop dropped.
REQ-014 Push at depth=128 SHALL be suppressed (st_push=0), set ovf; pop at depth=0 SHALL be suppressed, set unf.
REQ-015 burst_start SHALL latch base/cnt/dir; cnt=0 -> DONE next cycle, burst_err=0, no stack traffic.
REQ-016 Save with depth+cnt>128, or restore with cnt>depth, SHALL go to DONE with burst_err=1, set ovf/unf respectively, no stack traffic.
REQ-017 SAVE SHALL push one word per cycle: rf_addr=base+i, st_d=rf_rdata, i=0..cnt-1; cnt cycles, then DONE.
REQ-018 RPOP SHALL pop one word per cycle in reverse order, register index base+cnt-1 down to base.
REQ-019 Each popped word SHALL be written the following cycle: rf_we=1, rf_wdata=st_q, rf_addr=its index.
REQ-020 After the last pop, RLAST SHALL perform the final write; restore takes cnt+1 cycles, then DONE.
REQ-021 rf_addr arithmetic SHALL be 4-bit modulo 16 (base+i wraps 15->0).
REQ-022 DONE SHALL pulse burst_done for one cycle and return to IDLE.
REQ-023 depth SHALL track every issued st_push/st_pop exactly; never exceed 128 or go below 0.
REQ-024 err_clr SHALL clear ovf and unf next edge; a simultaneous new error SHALL win (flag stays set).
REQ-025 Outside the states named, st_push, st_pop, rf_we, burst_done SHALL be 0.

Reset
REQ-026 reset_n low SHALL force IDLE, depth=0, ovf=0, unf=0, irq=0, all strobes 0, rf_addr=0, st_d=0, rf_wdata=0.
REQ-027 Reset mid-burst SHALL abort immediately; no burst_done; partial stack contents untouched.

Configuration
REQ-028 With STACK_CTRL_UFLOW_IRQ_EN defined, irq SHALL pulse one cycle on each suppressed pop or rejected restore.
REQ-029 Without STACK_CTRL_UFLOW_IRQ_EN, irq SHALL be tied 0; port kept.

Verification
REQ-030 Reset, cpu_push 0xA5A5A5A5 then cpu_pop -> st_push then st_pop asserted, depth 0->1->0, no flags.
REQ-031 Save base=14 cnt=4 with regs 14,15,0,1 = 1..4 -> pushes 1,2,3,4 in 4 cycles, depth=4, burst_done, err=0.
REQ-032 Restore base=14 cnt=4 -> writes reg1=4, reg0=3, reg15=2, reg14=1 on cycles 2..5, depth=0.
REQ-033 128 CPU pushes then one more push -> depth=128, st_push suppressed, ovf=1; err_clr -> ovf=0.
REQ-034 Restore cnt=3 at depth=2 -> burst_done with burst_err=1, unf=1, no st_pop; irq pulse only with macro.
REQ-035 burst_start with cpu_push same cycle, then reset_n low mid-SAVE -> CPU push dropped, state IDLE, depth=0, no burst_done.
